// File: rtl/dma_write_arbiter.sv
// dma_write_arbiter: round-robin sharing of one DMA write cmd+data channel
// among NUM_PORTS requesters. A grant is taken per transfer and held from
// command accept through the data beat carrying last; per-port completed
// transfer counters feed host status registers.
module dma_write_arbiter #(
   parameter  int NUM_PORTS  = 4,
   parameter  int DATA_WIDTH = 512,
   localparam int ID_WIDTH   = $clog2(NUM_PORTS),
   localparam int KEEP_WIDTH = DATA_WIDTH / 8
) (
   input  logic                             clk,
   input  logic                             rstn,
   input  logic [NUM_PORTS-1:0]             s_cmd_valid,
   output logic [NUM_PORTS-1:0]             s_cmd_ready,
   input  logic [NUM_PORTS*64-1:0]          s_cmd_address,
   input  logic [NUM_PORTS*32-1:0]          s_cmd_length,
   input  logic [NUM_PORTS-1:0]             s_data_valid,
   output logic [NUM_PORTS-1:0]             s_data_ready,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_data_data,
   input  logic [NUM_PORTS*KEEP_WIDTH-1:0]  s_data_keep,
   input  logic [NUM_PORTS-1:0]             s_data_last,
   output logic                             m_cmd_valid,
   input  logic                             m_cmd_ready,
   output logic [63:0]                      m_cmd_address,
   output logic [31:0]                      m_cmd_length,
   output logic                             m_data_valid,
   input  logic                             m_data_ready,
   output logic [DATA_WIDTH-1:0]            m_data_data,
   output logic [KEEP_WIDTH-1:0]            m_data_keep,
   output logic                             m_data_last,
   output logic                             busy,
   output logic [ID_WIDTH-1:0]              grant_id,
   output logic [NUM_PORTS*32-1:0]          done_count
);

   typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_t;

   state_t                          r_state;
   state_t                          w_state_nxt;
   logic [ID_WIDTH-1:0]             r_rr_ptr;
   logic [ID_WIDTH-1:0]             r_grant;
   logic [NUM_PORTS-1:0][31:0]      r_done_cnt;

   // per-port views of the flat payload buses
   logic [NUM_PORTS-1:0][63:0]          w_addr;
   logic [NUM_PORTS-1:0][31:0]          w_len;
   logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] w_data;
   logic [NUM_PORTS-1:0][KEEP_WIDTH-1:0] w_keep;

   logic                            w_any_req;
   logic                            w_found_hi;
   logic                            w_found_lo;
   logic [ID_WIDTH-1:0]             w_pick_hi;
   logic [ID_WIDTH-1:0]             w_pick_lo;
   logic [ID_WIDTH-1:0]             w_pick;
   logic                            w_cmd_hs;
   logic                            w_data_done;

   assign w_addr = s_cmd_address;
   assign w_len  = s_cmd_length;
   assign w_data = s_data_data;
   assign w_keep = s_data_keep;

   assign w_any_req   = |s_cmd_valid;
   assign w_pick      = w_found_hi ? w_pick_hi : w_pick_lo;
   assign w_cmd_hs    = (r_state == ST_CMD) && s_cmd_valid[r_grant] && m_cmd_ready;
   assign w_data_done = (r_state == ST_DATA) && s_data_valid[r_grant] && m_data_ready
                        && s_data_last[r_grant];

   assign busy       = (r_state != ST_IDLE);
   assign grant_id   = r_grant;
   assign done_count = r_done_cnt;

   // Round-robin pick: lowest requester above rr_ptr wins, else lowest at or
   // below rr_ptr (wrap-around). Descending scan leaves the lowest index.
   always_comb begin
      w_found_hi = 1'b0;
      w_found_lo = 1'b0;
      w_pick_hi  = '0;
      w_pick_lo  = '0;
      for (int j = NUM_PORTS - 1; j >= 0; j--) begin
         if (s_cmd_valid[j]) begin
            if (j > int'(r_rr_ptr)) begin
               w_found_hi = 1'b1;
               w_pick_hi  = ID_WIDTH'(j);
            end else begin
               w_found_lo = 1'b1;
               w_pick_lo  = ID_WIDTH'(j);
            end
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // FSM next state: arbitrate in IDLE, hold grant through cmd and data
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_any_req)   w_state_nxt = ST_CMD;
         ST_CMD:  if (w_cmd_hs)    w_state_nxt = ST_DATA;
         ST_DATA: if (w_data_done) w_state_nxt = ST_IDLE;
         default:                  w_state_nxt = ST_IDLE;
      endcase
   end

   // Grant pointer and completion counters (counters wrap silently)
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rr_ptr   <= ID_WIDTH'(NUM_PORTS - 1);
         r_grant    <= '0;
         r_done_cnt <= '0;
      end else begin
         if (r_state == ST_IDLE && w_any_req) begin
            r_grant  <= w_pick;
            r_rr_ptr <= w_pick;
         end
         if (w_data_done) r_done_cnt[r_grant] <= r_done_cnt[r_grant] + 32'd1;
      end
   end

   // FSM outputs: combinational pass-through from the granted port only
   always_comb begin
      m_cmd_valid   = 1'b0;
      m_cmd_address = '0;
      m_cmd_length  = '0;
      m_data_valid  = 1'b0;
      m_data_data   = '0;
      m_data_keep   = '0;
      m_data_last   = 1'b0;
      s_cmd_ready   = '0;
      s_data_ready  = '0;
      case (r_state)
         ST_CMD: begin
            m_cmd_valid          = s_cmd_valid[r_grant];
            m_cmd_address        = w_addr[r_grant];
            m_cmd_length         = w_len[r_grant];
            s_cmd_ready[r_grant] = m_cmd_ready;
         end
         ST_DATA: begin
            m_data_valid          = s_data_valid[r_grant];
            m_data_data           = w_data[r_grant];
            m_data_keep           = w_keep[r_grant];
            m_data_last           = s_data_last[r_grant];
            s_data_ready[r_grant] = m_data_ready;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dma_write_arbiter.sv
// Directed bench for dma_write_arbiter: reset state, single transfer timing,
// round-robin order, long burst under backpressure, no cross-port
// forwarding, mid-burst reset and counter wrap.
module tb_dma_write_arbiter;
   localparam int NP = 4;
   localparam int DW = 64;
   localparam int KW = DW / 8;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   logic [NP-1:0]          s_cmd_valid, s_cmd_ready, s_data_valid, s_data_ready, s_data_last;
   logic [NP-1:0][63:0]    addr;
   logic [NP-1:0][31:0]    len;
   logic [NP-1:0][DW-1:0]  sdata;
   logic [NP-1:0][KW-1:0]  skeep;
   logic                   m_cmd_valid, m_cmd_ready, m_data_valid, m_data_ready, m_data_last;
   logic [63:0]            m_cmd_address;
   logic [31:0]            m_cmd_length;
   logic [DW-1:0]          m_data_data;
   logic [KW-1:0]          m_data_keep;
   logic                   busy;
   logic [1:0]             grant_id;
   logic [NP-1:0][31:0]    dcnt;

   dma_write_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rstn(rstn),
      .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
      .s_cmd_address(addr), .s_cmd_length(len),
      .s_data_valid(s_data_valid), .s_data_ready(s_data_ready),
      .s_data_data(sdata), .s_data_keep(skeep), .s_data_last(s_data_last),
      .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
      .m_cmd_address(m_cmd_address), .m_cmd_length(m_cmd_length),
      .m_data_valid(m_data_valid), .m_data_ready(m_data_ready),
      .m_data_data(m_data_data), .m_data_keep(m_data_keep), .m_data_last(m_data_last),
      .busy(busy), .grant_id(grant_id), .done_count(dcnt)
   );

   int n_chk = 0;
   int n_pass = 0;

   // requester model state
   int  xl[NP];       // transfers left
   int  bp[NP];       // beats per transfer
   int  bi[NP];       // current beat
   bit  ind[NP];      // command accepted, sending data
   bit  fdv[NP];      // hold data valid without a command
   int  tb_done[NP];
   bit  rdy_mode;     // 1: toggle m_data_ready every cycle
   // monitor state
   int  n_beats, n_data_err, n_ready_err, rdy1, mon_beat;
   logic [1:0] order[$];
   logic [NP-1:0] chs, dhs, dl;

   task automatic drive_ports();
      for (int p = 0; p < NP; p++) begin
         s_cmd_valid[p]  = (xl[p] > 0) && !ind[p];
         addr[p]         = 64'h1000 + 64'(p) * 64'h100;
         len[p]          = 32'(bp[p] * 8);
         s_data_valid[p] = ind[p] | fdv[p];
         s_data_last[p]  = ind[p] && (bi[p] == bp[p] - 1);
         sdata[p]        = {32'(p), 32'(bi[p])};
         skeep[p]        = s_data_last[p] ? 8'h0F : 8'hFF;
      end
   endtask

   function automatic bit all_done();
      for (int p = 0; p < NP; p++) if (xl[p] != 0 || ind[p]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int ord_code();
      int c = 0;
      foreach (order[i]) c = c * 10 + int'(order[i]) + 1;
      return c;
   endfunction

   // one clock: observe at negedge, update model and drive after posedge
   task automatic cycle();
      @(negedge clk);
      if (|((s_cmd_ready | s_data_ready) & ~(4'b0001 << grant_id))) n_ready_err++;
      if (s_cmd_ready[1] | s_data_ready[1]) rdy1++;
      if (m_cmd_valid && m_cmd_ready) begin
         order.push_back(grant_id);
         if (m_cmd_address !== 64'h1000 + 64'(grant_id) * 64'h100) n_data_err++;
      end
      if (m_data_valid && m_data_ready) begin
         n_beats++;
         if (m_data_data !== {32'(grant_id), 32'(mon_beat)}) n_data_err++;
         if (m_data_keep !== (m_data_last ? 8'h0F : 8'hFF)) n_data_err++;
         mon_beat = m_data_last ? 0 : mon_beat + 1;
      end
      chs = s_cmd_valid & s_cmd_ready;
      dhs = s_data_valid & s_data_ready;
      dl  = s_data_last;
      @(posedge clk); #1;
      for (int p = 0; p < NP; p++) begin
         if (chs[p]) ind[p] = 1'b1;
         if (dhs[p]) begin
            if (dl[p]) begin
               ind[p] = 1'b0; xl[p]--; bi[p] = 0; tb_done[p]++;
            end else bi[p]++;
         end
      end
      if (rdy_mode) m_data_ready = ~m_data_ready;
      drive_ports();
   endtask

   task automatic reset_dut();
      rstn = 1'b0;
      for (int p = 0; p < NP; p++) begin
         xl[p] = 0; bp[p] = 0; bi[p] = 0; ind[p] = 0; fdv[p] = 0; tb_done[p] = 0;
      end
      rdy_mode = 0; n_beats = 0; n_data_err = 0; n_ready_err = 0; rdy1 = 0; mon_beat = 0;
      order.delete();
      m_cmd_ready = 1'b1; m_data_ready = 1'b1;
      drive_ports();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      m_cmd_ready = 1'b1; m_data_ready = 1'b1;
      s_cmd_valid = '1; s_data_valid = '1; s_data_last = '1;
      addr = '1; len = '1; sdata = '1; skeep = '1;
      repeat (2) @(negedge clk);
      n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b exp 0", busy); else n_pass++;
      n_chk++; if (grant_id !== 2'd0) $display("FAIL reset_grant got %0d exp 0", grant_id); else n_pass++;
      n_chk++; if (dcnt !== '0) $display("FAIL reset_done_count got %h exp 0", dcnt); else n_pass++;
      n_chk++; if ({m_cmd_valid, m_data_valid, s_cmd_ready, s_data_ready} !== 10'd0)
         $display("FAIL reset_valid_ready got %b exp 0", {m_cmd_valid, m_data_valid, s_cmd_ready, s_data_ready});
      else n_pass++;
      n_chk++; if ({m_cmd_address, m_cmd_length, m_data_data, m_data_keep, m_data_last} !== '0)
         $display("FAIL reset_payload got %h/%h/%h exp 0", m_cmd_address, m_cmd_length, m_data_data);
      else n_pass++;
   endtask

   task automatic test_single();
      reset_dut();
      @(posedge clk); #1;
      s_cmd_valid = 4'b0001; addr[0] = 64'h1000; len[0] = 32'h40;
      @(negedge clk);
      n_chk++; if ({busy, m_cmd_valid, s_cmd_ready} !== 6'd0)
         $display("FAIL single_idle got %b exp 0", {busy, m_cmd_valid, s_cmd_ready}); else n_pass++;
      @(negedge clk);
      n_chk++; if ({busy, m_cmd_valid, s_cmd_ready, grant_id} !== {2'b11, 4'b0001, 2'd0})
         $display("FAIL single_cmd got %b exp 11000100", {busy, m_cmd_valid, s_cmd_ready, grant_id}); else n_pass++;
      n_chk++; if ({m_cmd_address, m_cmd_length} !== {64'h1000, 32'h40})
         $display("FAIL single_cmd_payload got %h %h exp 1000 40", m_cmd_address, m_cmd_length); else n_pass++;
      @(posedge clk); #1;
      s_cmd_valid = '0; s_data_valid = 4'b0001; s_data_last = 4'b0001;
      sdata[0] = 64'hDEAD_BEEF_0000_0001; skeep[0] = 8'hFF;
      @(negedge clk);
      n_chk++; if ({m_data_valid, m_data_last, s_data_ready, m_cmd_valid} !== 7'b1100010)
         $display("FAIL single_data_ctl got %b exp 1100010", {m_data_valid, m_data_last, s_data_ready, m_cmd_valid}); else n_pass++;
      n_chk++; if ({m_data_data, m_data_keep} !== {64'hDEAD_BEEF_0000_0001, 8'hFF})
         $display("FAIL single_data got %h %h exp deadbeef00000001 ff", m_data_data, m_data_keep); else n_pass++;
      @(posedge clk); #1;
      s_data_valid = '0; s_data_last = '0;
      @(negedge clk);
      n_chk++; if ({busy, m_data_valid} !== 2'b00) $display("FAIL single_back_idle got %b exp 00", {busy, m_data_valid}); else n_pass++;
      n_chk++; if (dcnt !== {32'd0, 32'd0, 32'd0, 32'd1}) $display("FAIL single_done_count got %h exp ...0001", dcnt); else n_pass++;
   endtask

   task automatic test_round_robin();
      reset_dut();
      for (int p = 0; p < NP; p++) begin xl[p] = 2; bp[p] = 2; end
      drive_ports();
      for (int k = 0; k < 200 && !all_done(); k++) cycle();
      n_chk++; if (all_done() !== 1'b1) $display("FAIL rr_timeout got pending exp done"); else n_pass++;
      n_chk++; if (ord_code() !== 12341234) $display("FAIL rr_order got %0d exp 12341234 (port+1 digits)", ord_code()); else n_pass++;
      n_chk++; if (dcnt !== {32'd2, 32'd2, 32'd2, 32'd2}) $display("FAIL rr_done_count got %h exp all 2", dcnt); else n_pass++;
      n_chk++; if (n_beats !== 16) $display("FAIL rr_beats got %0d exp 16", n_beats); else n_pass++;
      n_chk++; if ({n_data_err, n_ready_err} !== 64'd0)
         $display("FAIL rr_integrity got data_err=%0d ready_err=%0d exp 0", n_data_err, n_ready_err); else n_pass++;
   endtask

   task automatic test_long_burst();
      reset_dut();
      xl[2] = 1; bp[2] = 32768; rdy_mode = 1;
      drive_ports();
      for (int k = 0; k < 10 && !busy; k++) cycle();
      xl[1] = 1; bp[1] = 1; fdv[1] = 1; rdy1 = 0;
      drive_ports();
      for (int k = 0; k < 70000 && tb_done[2] == 0; k++) cycle();
      n_chk++; if (tb_done[2] !== 1) $display("FAIL long_timeout got %0d exp 1", tb_done[2]); else n_pass++;
      n_chk++; if (n_beats !== 32768) $display("FAIL long_beats got %0d exp 32768", n_beats); else n_pass++;
      n_chk++; if (rdy1 !== 0) $display("FAIL long_port1_ready got %0d cycles exp 0", rdy1); else n_pass++;
      for (int k = 0; k < 20 && !all_done(); k++) cycle();
      n_chk++; if (ord_code() !== 32) $display("FAIL long_order got %0d exp 32 (port+1 digits)", ord_code()); else n_pass++;
      n_chk++; if (dcnt !== {32'd0, 32'd1, 32'd1, 32'd0}) $display("FAIL long_done_count got %h exp 0/1/1/0", dcnt); else n_pass++;
      n_chk++; if ({n_data_err, n_ready_err} !== 64'd0)
         $display("FAIL long_integrity got data_err=%0d ready_err=%0d exp 0", n_data_err, n_ready_err); else n_pass++;
   endtask

   task automatic test_no_forward();
      reset_dut();
      xl[3] = 1; bp[3] = 4; fdv[1] = 1;
      drive_ports();
      for (int k = 0; k < 30 && !all_done(); k++) cycle();
      repeat (4) cycle();
      n_chk++; if (n_beats !== 4) $display("FAIL nofwd_beats got %0d exp 4", n_beats); else n_pass++;
      n_chk++; if (rdy1 !== 0) $display("FAIL nofwd_port1_ready got %0d cycles exp 0", rdy1); else n_pass++;
      n_chk++; if (dcnt !== {32'd1, 32'd0, 32'd0, 32'd0}) $display("FAIL nofwd_done_count got %h exp 1/0/0/0", dcnt); else n_pass++;
      @(negedge clk);
      n_chk++; if ({m_data_valid, s_data_valid[1]} !== 2'b01)
         $display("FAIL nofwd_idle_valid got m=%0b s1=%0b exp m=0 s1=1", m_data_valid, s_data_valid[1]); else n_pass++;
      n_chk++; if ({n_data_err, n_ready_err} !== 64'd0)
         $display("FAIL nofwd_integrity got data_err=%0d ready_err=%0d exp 0", n_data_err, n_ready_err); else n_pass++;
   endtask

   task automatic test_reset_mid();
      reset_dut();
      xl[3] = 1; bp[3] = 1;
      drive_ports();
      for (int k = 0; k < 20 && !all_done(); k++) cycle();
      xl[1] = 1; bp[1] = 512;
      drive_ports();
      for (int k = 0; k < 300 && n_beats < 101; k++) cycle();
      n_chk++; if ({busy, grant_id, dcnt[3]} !== {1'b1, 2'd1, 32'd1})
         $display("FAIL mid_pre_state got busy=%0b grant=%0d dc3=%0d exp 1 1 1", busy, grant_id, dcnt[3]); else n_pass++;
      #2 rstn = 1'b0;
      #1;
      n_chk++; if ({busy, grant_id, m_data_valid, m_cmd_valid, s_data_ready, s_cmd_ready} !== 12'd0)
         $display("FAIL mid_reset_ctl got %b exp 0", {busy, grant_id, m_data_valid, m_cmd_valid, s_data_ready, s_cmd_ready});
      else n_pass++;
      n_chk++; if ({m_data_data, m_data_last} !== '0) $display("FAIL mid_reset_payload got %h exp 0", m_data_data); else n_pass++;
      n_chk++; if (dcnt !== '0) $display("FAIL mid_reset_done_count got %h exp 0", dcnt); else n_pass++;
      reset_dut();
      for (int p = 0; p < NP; p++) begin xl[p] = 1; bp[p] = 1; end
      drive_ports();
      for (int k = 0; k < 10 && order.size() == 0; k++) cycle();
      n_chk++; if (order.size() == 0 || order[0] !== 2'd0)
         $display("FAIL mid_first_grant got %0d exp 0", order.size() == 0 ? -1 : int'(order[0])); else n_pass++;
   endtask

   task automatic test_wrap();
      reset_dut();
      @(negedge clk);
      force dut.r_done_cnt = {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF};
      @(posedge clk); #1;
      release dut.r_done_cnt;
      @(negedge clk);
      n_chk++; if (dcnt[0] !== 32'hFFFF_FFFF) $display("FAIL wrap_preload got %h exp ffffffff", dcnt[0]); else n_pass++;
      @(posedge clk); #1;
      xl[0] = 1; bp[0] = 2;
      drive_ports();
      for (int k = 0; k < 20 && !all_done(); k++) cycle();
      n_chk++; if (dcnt[0] !== 32'd0) $display("FAIL wrap_count got %h exp 0", dcnt[0]); else n_pass++;
      n_chk++; if (dcnt[3:1] !== '0) $display("FAIL wrap_others got %h exp 0", dcnt[3:1]); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_long_burst();
      test_no_forward();
      test_reset_mid();
      test_wrap();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
